// File: rtl/periph_bus_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : periph_bus_arbiter                                           |
// | Purpose : two-master arbiter onto one strobe-based peripheral bus      |
// | Rev     : 1.0  initial release                                         |
// +------------------------------------------------------------------------+
module periph_bus_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int FIXED_PRIO = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_rd,
  input  logic              m0_wr,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_ack,
  input  logic              m1_req,
  input  logic              m1_rd,
  input  logic              m1_wr,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_ack,
  output logic              p_rd,
  output logic              p_wr,
  output logic [ADDR_W-1:0] p_addr,
  output logic [DATA_W-1:0] p_wdata,
  input  logic [DATA_W-1:0] p_rdata,
  output logic              busy
);

  localparam logic [1:0] c_IDLE   = 2'd0;
  localparam logic [1:0] c_ACCESS = 2'd1;
  localparam logic [1:0] c_RESP   = 2'd2;

  logic [1:0]        r_state;
  logic [1:0]        w_next;
  logic              r_owner;
  logic              r_last_owner;
  logic              r_rd;
  logic              r_wr;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_m0_rdata;
  logic [DATA_W-1:0] r_m1_rdata;
  logic              w_any_req;
  logic              w_winner;
  logic [DATA_W-1:0] w_cap;

  // Tie-break: fixed priority favours master 0, otherwise alternate owners.
  always_comb begin
    w_any_req = m0_req | m1_req;
    w_winner  = m1_req;
    if (m0_req && m1_req) begin
      w_winner = (FIXED_PRIO != 0) ? 1'b0 : ~r_last_owner;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = c_IDLE;
    case (r_state)
      c_IDLE:   w_next = w_any_req ? c_ACCESS : c_IDLE;
      c_ACCESS: w_next = c_RESP;
      c_RESP:   w_next = c_IDLE;
      default:  w_next = c_IDLE;
    endcase
  end

  // Write wins over read; writes and null commands return zero.
  assign w_cap = (r_rd && !r_wr) ? p_rdata : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_owner      <= 1'b0;
      r_last_owner <= 1'b1;
      r_rd         <= 1'b0;
      r_wr         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_m0_rdata   <= '0;
      r_m1_rdata   <= '0;
    end else begin
      if (r_state == c_IDLE && w_any_req) begin
        r_owner      <= w_winner;
        r_last_owner <= w_winner;
        r_rd         <= w_winner ? m1_rd    : m0_rd;
        r_wr         <= w_winner ? m1_wr    : m0_wr;
        r_addr       <= w_winner ? m1_addr  : m0_addr;
        r_wdata      <= w_winner ? m1_wdata : m0_wdata;
      end
      if (r_state == c_ACCESS) begin
        if (r_owner) begin
          r_m1_rdata <= w_cap;
        end else begin
          r_m0_rdata <= w_cap;
        end
      end
    end
  end

  always_comb begin
    p_rd   = 1'b0;
    p_wr   = 1'b0;
    m0_ack = 1'b0;
    m1_ack = 1'b0;
    busy   = (r_state != c_IDLE);
    case (r_state)
      c_ACCESS: begin
        p_wr = r_wr;
        p_rd = r_rd & ~r_wr;
      end
      c_RESP: begin
        m0_ack = ~r_owner;
        m1_ack = r_owner;
      end
      default: ;
    endcase
  end

  assign p_addr   = r_addr;
  assign p_wdata  = r_wdata;
  assign m0_rdata = r_m0_rdata;
  assign m1_rdata = r_m1_rdata;

endmodule
`default_nettype wire

// File: tb/tb_periph_bus_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : tb_periph_bus_arbiter                                        |
// | Purpose : round-robin and fixed-priority instances vs timeline model   |
// | Rev     : 1.0  initial release                                         |
// +------------------------------------------------------------------------+
module tb_periph_bus_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // Index [i][m]: instance i (0 = round-robin, 1 = fixed priority), master m.
  logic        req   [2][2];
  logic        rd    [2][2];
  logic        wr    [2][2];
  logic [31:0] addr  [2][2];
  logic [31:0] wdata [2][2];
  logic [31:0] rdata [2][2];
  logic        ack   [2][2];
  logic        prd   [2];
  logic        pwr   [2];
  logic        busy  [2];
  logic [31:0] paddr [2];
  logic [31:0] pwdata[2];
  logic [31:0] prdata[2];

  function automatic logic [31:0] periph(input logic [31:0] a);
    return a ^ 32'h4000_00B5;
  endfunction

  assign prdata[0] = periph(paddr[0]);
  assign prdata[1] = periph(paddr[1]);

  periph_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .FIXED_PRIO(0)) u_rr (
    .clk(clk), .reset(reset),
    .m0_req(req[0][0]), .m0_rd(rd[0][0]), .m0_wr(wr[0][0]), .m0_addr(addr[0][0]),
    .m0_wdata(wdata[0][0]), .m0_rdata(rdata[0][0]), .m0_ack(ack[0][0]),
    .m1_req(req[0][1]), .m1_rd(rd[0][1]), .m1_wr(wr[0][1]), .m1_addr(addr[0][1]),
    .m1_wdata(wdata[0][1]), .m1_rdata(rdata[0][1]), .m1_ack(ack[0][1]),
    .p_rd(prd[0]), .p_wr(pwr[0]), .p_addr(paddr[0]), .p_wdata(pwdata[0]),
    .p_rdata(prdata[0]), .busy(busy[0])
  );

  periph_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .FIXED_PRIO(1)) u_fp (
    .clk(clk), .reset(reset),
    .m0_req(req[1][0]), .m0_rd(rd[1][0]), .m0_wr(wr[1][0]), .m0_addr(addr[1][0]),
    .m0_wdata(wdata[1][0]), .m0_rdata(rdata[1][0]), .m0_ack(ack[1][0]),
    .m1_req(req[1][1]), .m1_rd(rd[1][1]), .m1_wr(wr[1][1]), .m1_addr(addr[1][1]),
    .m1_wdata(wdata[1][1]), .m1_rdata(rdata[1][1]), .m1_ack(ack[1][1]),
    .p_rd(prd[1]), .p_wr(pwr[1]), .p_addr(paddr[1]), .p_wdata(pwdata[1]),
    .p_rdata(prdata[1]), .busy(busy[1])
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Timeline model: a grant at edge g gives a strobe interval after g, an ack
  // interval after g+1, and the next arbitration sample at edge g+3.
  int          ecount = 0;
  int          grant_e  [2];
  int          next_free[2];
  bit          own      [2];
  bit          last_own [2];
  bit          l_rd     [2];
  bit          l_wr     [2];
  logic [31:0] l_addr   [2];
  logic [31:0] l_wdata  [2];
  logic [31:0] e_rdata  [2][2];

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      grant_e[i]    = -100;
      next_free[i]  = 0;
      own[i]        = 1'b0;
      last_own[i]   = 1'b1;
      l_rd[i]       = 1'b0;
      l_wr[i]       = 1'b0;
      l_addr[i]     = '0;
      l_wdata[i]    = '0;
      e_rdata[i][0] = '0;
      e_rdata[i][1] = '0;
    end
  endtask

  task automatic model_step();
    bit w;
    ecount++;
    if (reset) begin
      model_reset();
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (ecount == grant_e[i] + 1)
          e_rdata[i][own[i]] = (l_rd[i] && !l_wr[i]) ? periph(l_addr[i]) : 32'h0;
        if (ecount >= next_free[i] && (req[i][0] || req[i][1])) begin
          if (req[i][0] && req[i][1]) w = (i == 1) ? 1'b0 : !last_own[i];
          else                        w = req[i][1];
          own[i]       = w;
          last_own[i]  = w;
          l_rd[i]      = rd[i][w];
          l_wr[i]      = wr[i][w];
          l_addr[i]    = addr[i][w];
          l_wdata[i]   = wdata[i][w];
          grant_e[i]   = ecount;
          next_free[i] = ecount + 3;
        end
      end
    end
  endtask

  function automatic bit in_access(input int i);
    return ecount == grant_e[i];
  endfunction

  function automatic bit exp_ack(input int i, input int m);
    return (ecount == grant_e[i] + 1) && (own[i] == m[0]);
  endfunction

  task automatic compare_all();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("i%0d busy", i),   busy[i],   in_access(i) || exp_ack(i, 0) || exp_ack(i, 1));
      chk($sformatf("i%0d p_wr", i),   pwr[i],    in_access(i) && l_wr[i]);
      chk($sformatf("i%0d p_rd", i),   prd[i],    in_access(i) && l_rd[i] && !l_wr[i]);
      chk($sformatf("i%0d p_addr", i), paddr[i],  l_addr[i]);
      chk($sformatf("i%0d p_wdata", i), pwdata[i], l_wdata[i]);
      for (int m = 0; m < 2; m++) begin
        chk($sformatf("i%0d m%0d_ack", i, m),   ack[i][m],   exp_ack(i, m));
        chk($sformatf("i%0d m%0d_rdata", i, m), rdata[i][m], e_rdata[i][m]);
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic set_cmd(input int m, input bit r, input bit w, input logic [31:0] a,
                         input logic [31:0] d);
    for (int i = 0; i < 2; i++) begin
      req[i][m]   = 1'b1;
      rd[i][m]    = r;
      wr[i][m]    = w;
      addr[i][m]  = a;
      wdata[i][m] = d;
    end
  endtask

  task automatic drop(input int m);
    for (int i = 0; i < 2; i++) begin
      req[i][m] = 1'b0;
      rd[i][m]  = 1'b0;
      wr[i][m]  = 1'b0;
    end
  endtask

  task automatic rand_cmd(input int i, input int m);
    rd[i][m]    = 1'($urandom_range(0, 1));
    wr[i][m]    = 1'($urandom_range(0, 1));
    addr[i][m]  = 32'h4000_0000 + 32'(4 * $urandom_range(0, 5));
    wdata[i][m] = $urandom;
  endtask

  task automatic drive_random();
    for (int i = 0; i < 2; i++) begin
      for (int m = 0; m < 2; m++) begin
        if (!req[i][m]) begin
          if ($urandom_range(0, 2) == 0) begin
            req[i][m] = 1'b1;
            rand_cmd(i, m);
          end
        end else if (exp_ack(i, m)) begin
          if ($urandom_range(0, 1) == 0) req[i][m] = 1'b0;
          else rand_cmd(i, m);
        end else if ($urandom_range(0, 3) == 0) begin
          rand_cmd(i, m);
        end
      end
    end
  endtask

  logic [3:0] seq[2];
  int         nack[2];

  initial begin
    for (int i = 0; i < 2; i++)
      for (int m = 0; m < 2; m++) begin
        req[i][m] = 1'b0; rd[i][m] = 1'b0; wr[i][m] = 1'b0;
        addr[i][m] = '0; wdata[i][m] = '0;
      end
    model_reset();
    reset = 1'b1;
    repeat (2) cycle();
    reset = 1'b0;
    repeat (10) cycle();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("i%0d idle busy", i), busy[i], 0);
      chk($sformatf("i%0d idle strobes", i), {prd[i], pwr[i]}, 0);
    end

    // Single master 0 write
    set_cmd(0, 1'b0, 1'b1, 32'h4000_000C, 32'h5A);
    cycle();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("i%0d wr strobe", i), pwr[i], 1);
      chk($sformatf("i%0d wr addr", i), paddr[i], 32'h4000_000C);
      chk($sformatf("i%0d wr data", i), pwdata[i], 32'h5A);
    end
    cycle();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("i%0d wr ack", i), {ack[i][0], ack[i][1]}, 2'b10);
      chk($sformatf("i%0d wr rdata", i), rdata[i][0], 0);
    end
    drop(0);
    cycle();

    // Single master 1 read
    set_cmd(1, 1'b1, 1'b0, 32'h4000_0010, 32'h0);
    cycle();
    for (int i = 0; i < 2; i++) chk($sformatf("i%0d rd strobe", i), {prd[i], pwr[i]}, 2'b10);
    cycle();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("i%0d rd ack", i), {ack[i][0], ack[i][1]}, 2'b01);
      chk($sformatf("i%0d rd rdata", i), rdata[i][1], 32'h0000_00A5);
    end
    drop(1);
    cycle();

    // Both masters held: alternation vs fixed priority
    set_cmd(0, 1'b0, 1'b1, 32'h4000_0000, 32'h11);
    set_cmd(1, 1'b1, 1'b0, 32'h4000_0004, 32'h0);
    for (int i = 0; i < 2; i++) begin seq[i] = '0; nack[i] = 0; end
    for (int k = 1; k <= 14; k++) begin
      cycle();
      if (k <= 11)
        for (int i = 0; i < 2; i++)
          if (ack[i][0] || ack[i][1]) begin
            seq[i] = {seq[i][2:0], ack[i][1]};
            nack[i]++;
          end
      if (k == 11) drop(0);
    end
    chk("rr grant order", {28'h0, seq[0]}, 32'h5);
    chk("rr ack count", nack[0], 4);
    chk("fp grant order", {28'h0, seq[1]}, 32'h0);
    chk("fp ack count", nack[1], 4);
    chk("fp m1 after m0 drops", ack[1][1], 1);
    drop(1);
    cycle();

    // Read and write both set: write wins, rdata zero
    set_cmd(1, 1'b1, 1'b1, 32'h4000_0014, 32'h33);
    cycle();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("i%0d rdwr strobes", i), {prd[i], pwr[i]}, 2'b01);
      chk($sformatf("i%0d rdwr addr", i), paddr[i], 32'h4000_0014);
    end
    cycle();
    for (int i = 0; i < 2; i++) chk($sformatf("i%0d rdwr rdata", i), rdata[i][1], 0);
    drop(1);
    cycle();

    // Reset asserted during the access phase
    set_cmd(0, 1'b0, 1'b1, 32'h4000_0008, 32'h77);
    cycle();
    for (int i = 0; i < 2; i++) chk($sformatf("i%0d pre-reset p_wr", i), pwr[i], 1);
    reset = 1'b1;
    #1;
    model_reset();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("i%0d abort p_wr", i), pwr[i], 0);
      chk($sformatf("i%0d abort busy", i), busy[i], 0);
    end
    drop(0);
    cycle();
    reset = 1'b0;
    repeat (2) cycle();
    for (int i = 0; i < 2; i++) chk($sformatf("i%0d no ack after abort", i), ack[i][0], 0);

    // Randomised traffic
    repeat (3000) begin
      cycle();
      drive_random();
    end
    drop(0);
    drop(1);
    repeat (6) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/periph_bus_arbiter.md
Name: periph_bus_arbiter

Overview:
- Two-master arbiter sharing the single memory-mapped peripheral bus (timer TH/TL/TCON, LED, switch and 7-seg registers at 0x4000_0000–0x4000_0014).
- Master 0 is the pipeline CPU MEM stage; master 1 is a secondary bus master (UART/DMA engine).
- Serialises accesses and drives one rd or wr strobe to the peripheral for exactly one cycle per transaction.
- Returns a registered read-data word and a one-cycle ack to the owning master.

Parameters:
- ADDR_W, 32: address width.
- DATA_W, 32: data width.
- FIXED_PRIO, 0: 0 selects round-robin; 1 means master 0 always wins a simultaneous request.

Ports:
- clk  in  1  system clock; all state changes on posedge.
- reset  in  1  asynchronous, active-high reset.
- m0_req  in  1  master 0 transaction request; held until m0_ack.
- m0_rd  in  1  master 0 read command.
- m0_wr  in  1  master 0 write command.
- m0_addr  in  ADDR_W  master 0 address.
- m0_wdata  in  DATA_W  master 0 write data.
- m0_rdata  out  DATA_W  read data returned to master 0 (registered).
- m0_ack  out  1  one-cycle completion pulse to master 0.
- m1_req, m1_rd, m1_wr, m1_addr, m1_wdata, m1_rdata, m1_ack: same as the master 0 signals, for master 1.
- p_rd  out  1  peripheral read strobe.
- p_wr  out  1  peripheral write strobe.
- p_addr  out  ADDR_W  peripheral address.
- p_wdata  out  DATA_W  peripheral write data.
- p_rdata  in  DATA_W  peripheral read data (combinational from peripheral).
- busy  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset values:
  - State IDLE; last_owner = 1, so master 0 wins the first tie.
  - m0/m1 ack = 0 and rdata = 0.
  - p_rd = p_wr = 0; p_addr = p_wdata = 0; busy = 0.
- Reset is asynchronous. Asserting it mid-transaction aborts immediately: no strobe and no ack are issued.
- State machine: IDLE -> ACCESS -> RESP -> IDLE.
- IDLE:
  - Sample m0_req/m1_req at the posedge.
  - If none are set, stay in IDLE.
  - If exactly one is set, grant it.
  - If both are set and FIXED_PRIO=1, grant master 0.
  - If both are set and FIXED_PRIO=0, grant the master that is not last_owner.
  - On a grant: latch owner, addr, wdata, and the command into internal registers, go to ACCESS, and set last_owner = owner.
- ACCESS (exactly 1 cycle):
  - p_addr/p_wdata are driven from the latched registers.
  - If the latched wr is set, p_wr = 1. If rd is set and wr is clear, p_rd = 1. wr wins when both are set.
  - If neither is set (null transaction), neither strobe is asserted.
  - At the closing posedge: owner rdata <= p_rdata if read, else 0; go to RESP.
  - The non-owner's rdata is unchanged.
- RESP (exactly 1 cycle):
  - owner_ack = 1; requests are not sampled; next state is IDLE.
  - The master must drop req, or present a new command, during its ack cycle.
- Strobes: p_rd/p_wr are never high outside ACCESS and never both high. p_addr/p_wdata hold their last values outside ACCESS.
- Latency and throughput:
  - req seen at posedge N -> strobe in cycle N+1 -> ack in cycle N+2.
  - Peak throughput is one transaction per 3 cycles.
- Inputs: master inputs are ignored after the grant latch. A master changing addr/wdata mid-transaction does not affect the access.
- Losing master: its request stays pending and is granted at the next IDLE sample.
- Starvation bounds:
  - With FIXED_PRIO=0, a requester waits at most one foreign transaction (≤3 cycles plus the IDLE cycle).
  - With FIXED_PRIO=1, master 1 may starve while master 0 requests back-to-back. This is intended.
- Widths: no arithmetic; all paths are pass-through at DATA_W/ADDR_W. rdata is zero-filled for writes and for null transactions.

Test Plan:
- Reset then idle: reset=1 for 2 cycles, then release with no req -> busy=0, p_rd=p_wr=0, both acks 0 for 10 cycles.
- Single M0 write: m0_req=1, m0_wr=1, addr=0x4000000C, wdata=0x5A -> next cycle p_wr=1, p_addr=0x4000000C, p_wdata=0x5A for 1 cycle; following cycle m0_ack=1 and m0_rdata=0; m1_ack stays 0.
- Single M1 read: m1_req=1, m1_rd=1, addr=0x40000010, bench p_rdata=0x000000A5 -> p_rd=1 for 1 cycle; next cycle m1_ack=1, m1_rdata=0xA5.
- Round-robin tie (FIXED_PRIO=0): both req held for 4 transactions -> grant order M0, M1, M0, M1; acks alternate every 3 cycles.
- Fixed priority (FIXED_PRIO=1): both req held for 3 transactions -> all to M0, m1_ack never asserted; drop m0_req -> M1 granted at the next IDLE.
- Mid-transaction reset and rd+wr conflict:
  - reset=1 during ACCESS -> p_wr drops immediately; no ack; state IDLE after release.
  - Command with rd=wr=1, addr=0x40000014 -> only p_wr pulses; rdata=0.
